// File: rtl/mem_stage_mo_pkg.sv
// Shared encodings and queue entry type for the multi-outstanding MEM stage.
package mem_stage_mo_pkg;

    localparam logic [2:0] LD_OP_NONE = 3'b000;
    localparam logic [2:0] LD_OP_W    = 3'b001;
    localparam logic [2:0] LD_OP_B    = 3'b010;
    localparam logic [2:0] LD_OP_BU   = 3'b011;
    localparam logic [2:0] LD_OP_H    = 3'b100;
    localparam logic [2:0] LD_OP_HU   = 3'b101;

    localparam int BUSY_W = 32;

    // Payload is kept in a separate array because its width is a parameter of the stage.
    typedef struct packed {
        logic        need_resp;
        logic        got;
        logic [31:0] rdata;
        logic [2:0]  ld_op;
        logic [1:0]  addr;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
    } ms_entry_t;

endpackage

// File: rtl/mem_stage_mo_chk.sv
// Simulation-only checks on the MEM stage response path.
module mem_stage_mo_chk (
    input logic clk,
    input logic reset,
    input logic data_ok,
    input logic resp_taken
);

    // A response must be either discarded or matched to a waiting entry.
    resp_match_a: assert property (@(posedge clk) disable iff (reset) data_ok |-> resp_taken);

endmodule

// File: rtl/mem_stage_mo_load_align.sv
// Load data formatter: selects byte/half/word from rdata and extends it,
// or passes the ALU result through for non-load instructions.
module mem_load_align
    import mem_stage_mo_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] alu_result,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by sign or zero extension.
    always_comb begin
        case (addr)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (ld_op)
            LD_OP_W:  result = rdata;
            LD_OP_B:  result = {{24{byte_s[7]}}, byte_s};
            LD_OP_BU: result = {24'h000000, byte_s};
            LD_OP_H:  result = {{16{half_s[15]}}, half_s};
            LD_OP_HU: result = {16'h0000, half_s};
            default:  result = alu_result;
        endcase
    end

endmodule

// File: rtl/mem_stage_mo.sv
// Multi-outstanding MEM stage: in-order queue between EX and WB with response
// matching, post-flush discard counting and load formatting.
// Optional macro MS_RESP_BYPASS_EN lets a response to the head entry complete it in the same cycle.
module mem_stage_mo
    import mem_stage_mo_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 160
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         es_to_ms_valid,
    output logic                         ms_allowin,
    input  logic                         es_req_issued,
    input  logic [2:0]                   es_ld_op,
    input  logic [31:0]                  es_alu_result,
    input  logic                         es_gr_we,
    input  logic [4:0]                   es_dest,
    input  logic [PAYLOAD_W-1:0]         es_payload,
    input  logic                         data_ok,
    input  logic [31:0]                  rdata,
    input  logic                         ws_allowin,
    output logic                         ms_to_ws_valid,
    output logic [31:0]                  ms_to_ws_result,
    output logic                         ms_to_ws_gr_we,
    output logic [4:0]                   ms_to_ws_dest,
    output logic [PAYLOAD_W-1:0]         ms_to_ws_payload,
    output logic [BUSY_W-1:0]            ms_busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]   ms_outstanding
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ms_entry_t            ent_r     [DEPTH];
    logic [PAYLOAD_W-1:0] payload_r [DEPTH];
    logic [DEPTH-1:0]     valid_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     discard_cnt_r;

    logic [PTR_W-1:0]     idx_s;
    logic [PTR_W-1:0]     resp_ptr_s;
    logic                 pend_i_s;
    logic                 resp_hit_s;
    logic [CNT_W-1:0]     pend_cnt_s;
    logic [BUSY_W-1:0]    busy_s;
    ms_entry_t            head_s;
    logic [31:0]          head_rdata_s;
    logic                 discard_dec_s;
    logic                 resp_wr_s;
    logic                 bypass_s;
    logic                 head_ready_s;
    logic                 push_s;
    logic                 pop_s;

    // Oldest entry still awaiting a response (scanned from the head), pending count and GPR busy mask.
    always_comb begin
        idx_s      = rd_ptr_r;
        pend_i_s   = 1'b0;
        resp_ptr_s = rd_ptr_r;
        resp_hit_s = 1'b0;
        pend_cnt_s = '0;
        busy_s     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = rd_ptr_r + PTR_W'(i);
            pend_i_s   = valid_r[idx_s] && ent_r[idx_s].need_resp && !ent_r[idx_s].got;
            pend_cnt_s = pend_cnt_s + CNT_W'(pend_i_s);
            resp_ptr_s = (pend_i_s && !resp_hit_s) ? idx_s : resp_ptr_s;
            resp_hit_s = resp_hit_s | pend_i_s;
            busy_s[ent_r[i].dest] = busy_s[ent_r[i].dest] |
                (valid_r[i] && ent_r[i].gr_we && (ent_r[i].dest != 5'd0));
        end
    end

    assign head_s        = ent_r[rd_ptr_r];
    assign discard_dec_s = data_ok && (discard_cnt_r != '0);
    assign resp_wr_s     = data_ok && !discard_dec_s && resp_hit_s;

`ifdef MS_RESP_BYPASS_EN
    assign bypass_s = resp_wr_s && (resp_ptr_s == rd_ptr_r);
`else
    assign bypass_s = 1'b0;
`endif

    assign head_rdata_s   = bypass_s ? rdata : head_s.rdata;
    assign head_ready_s   = valid_r[rd_ptr_r] && (!head_s.need_resp || head_s.got || bypass_s);
    assign ms_to_ws_valid = head_ready_s && !flush;
    assign pop_s          = ms_to_ws_valid && ws_allowin;
    // Queued entries plus cancelled-but-unanswered requests share one budget of DEPTH.
    assign ms_allowin     = !flush &&
        (((CNT_W+1)'(count_r) + (CNT_W+1)'(discard_cnt_r)) < (CNT_W+1)'(DEPTH));
    assign push_s         = es_to_ms_valid && ms_allowin;

    assign ms_to_ws_gr_we   = head_s.gr_we;
    assign ms_to_ws_dest    = head_s.dest;
    assign ms_to_ws_payload = payload_r[rd_ptr_r];
    assign ms_busy_mask     = busy_s;
    assign ms_outstanding   = pend_cnt_s + discard_cnt_r;

    mem_load_align u_align (
        .ld_op      (head_s.ld_op),
        .addr       (head_s.addr),
        .rdata      (head_rdata_s),
        .alu_result (head_s.alu_result),
        .result     (ms_to_ws_result)
    );

    // Queue state update: flush bookkeeping, or response capture, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r       <= '0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            discard_cnt_r <= '0;
        end else if (flush) begin
            valid_r       <= '0;
            rd_ptr_r      <= '0;
            wr_ptr_r      <= '0;
            count_r       <= '0;
            discard_cnt_r <= discard_cnt_r + pend_cnt_s - CNT_W'(discard_dec_s || resp_wr_s);
        end else begin
            if (resp_wr_s) begin
                ent_r[resp_ptr_s].got   <= 1'b1;
                ent_r[resp_ptr_s].rdata <= rdata;
            end
            if (push_s) begin
                ent_r[wr_ptr_r] <= '{need_resp:  es_req_issued,
                                     got:        1'b0,
                                     rdata:      32'd0,
                                     ld_op:      es_ld_op,
                                     addr:       es_alu_result[1:0],
                                     alu_result: es_alu_result,
                                     gr_we:      es_gr_we,
                                     dest:       es_dest};
                payload_r[wr_ptr_r] <= es_payload;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            valid_r       <= (valid_r | (DEPTH'(push_s) << wr_ptr_r)) & ~(DEPTH'(pop_s) << rd_ptr_r);
            count_r       <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
            discard_cnt_r <= discard_cnt_r - CNT_W'(discard_dec_s);
        end
    end

    mem_stage_mo_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .data_ok    (data_ok),
        .resp_taken (discard_dec_s || resp_hit_s)
    );

endmodule
